// File: rtl/mem_port_arb_pkg.sv
// Shared types and constants for the data-cache port arbiter.
package mem_pkg;

  // FSM encoding is fixed so the debug state output is easy to decode.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10
  } state_t;

  // Lowest address bit that selects a 32-bit word.
  localparam int WORD_LSB = 2;

  typedef logic [3:0] be_t;

  localparam be_t BE_ALL = 4'hF;

  // True when two byte addresses fall in the same 32-bit word.
  function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
    return a[31:WORD_LSB] == b[31:WORD_LSB];
  endfunction

endpackage

// File: rtl/mem_port_arb_if.sv
// Request/response bundle between the MR/MW stages, the arbiter and the cache.
//
// Handshake: a requester raises mr_req/mw_req with stable address/data and
// holds it until the matching done pulse (the done cycle is the transfer
// cycle). Towards the cache, dc_req is the valid and dc_ack the ready; the
// access fields are held constant from dc_req rising until the dc_ack cycle.
interface mem_port_arb_if;
  import mem_pkg::*;

  logic        mr_req;
  logic [31:0] mr_addr;
  logic        mw_req;
  logic [31:0] mw_addr;
  logic [31:0] mw_data;
  be_t         mw_be;

  logic        dc_req;
  logic        dc_we;
  logic [31:0] dc_addr;
  logic [31:0] dc_wdata;
  be_t         dc_be;
  logic        dc_ack;
  logic [31:0] dc_rdata;

  logic        mr_done;
  logic        mw_done;
  logic [31:0] mr_rdata;
  logic        mr_stall;
  logic        mw_stall;

  // Arbiter side.
  modport slave (
    input  mr_req, mr_addr, mw_req, mw_addr, mw_data, mw_be, dc_ack, dc_rdata,
    output dc_req, dc_we, dc_addr, dc_wdata, dc_be,
    output mr_done, mw_done, mr_rdata, mr_stall, mw_stall
  );

  // Environment side: pipeline requesters plus the cache.
  modport master (
    output mr_req, mr_addr, mw_req, mw_addr, mw_data, mw_be, dc_ack, dc_rdata,
    input  dc_req, dc_we, dc_addr, dc_wdata, dc_be,
    input  mr_done, mw_done, mr_rdata, mr_stall, mw_stall
  );

endinterface

// File: rtl/mem_port_arb_starve_ctr.sv
// Saturating count of write grants taken while a read was waiting.
module arb_starve_ctr #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_i,
  input  logic       clr_i,
  output logic       at_max_o,
  output logic [3:0] cnt_o
);

  localparam logic [3:0] MAX = 4'(STARVE_MAX);

  logic [3:0] cnt_q, cnt_d;

  // Clear wins over increment; the count never passes MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 4'd0;
    end else if (inc_i && (cnt_q < MAX)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q >= MAX);
  assign cnt_o    = cnt_q;

endmodule

// File: rtl/mem_port_arb.sv
// Single data-cache port shared by the MR and MW stages: one access at a
// time, writes first, starvation guard for reads, same-word hazard override.
module mem_port_arb
  import mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_port_arb_if.slave  port,
  output state_t         state_o,
  output logic [3:0]     starve_cnt_o
);

  state_t      state_q, state_d;
  logic        grant_rd, grant_wr;
  logic        mr_done, mw_done;
  logic        at_max;
  logic        starve_inc, starve_clr;

  logic        dc_req_q, dc_we_q;
  logic [31:0] dc_addr_q, dc_wdata_q, mr_rdata_q;
  be_t         dc_be_q;

  // Arbitration in IDLE, completion detection while busy.
  always_comb begin
    state_d  = state_q;
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    mr_done  = 1'b0;
    mw_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (port.mr_req && port.mw_req) begin
          // A read never overtakes an older write to the same word.
          if (same_word(port.mr_addr, port.mw_addr)) begin
            grant_wr = 1'b1;
          end else if (at_max) begin
            grant_rd = 1'b1;
          end else begin
            grant_wr = 1'b1;
          end
        end else if (port.mr_req) begin
          grant_rd = 1'b1;
        end else if (port.mw_req) begin
          grant_wr = 1'b1;
        end
        if (grant_rd) begin
          state_d = RD;
        end else if (grant_wr) begin
          state_d = WR;
        end
      end
      RD: begin
        if (port.dc_ack) begin
          mr_done = 1'b1;
          state_d = IDLE;
        end
      end
      WR: begin
        if (port.dc_ack) begin
          mw_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the winning access on grant; drop dc_req after the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc_req_q   <= 1'b0;
      dc_we_q    <= 1'b0;
      dc_addr_q  <= 32'd0;
      dc_wdata_q <= 32'd0;
      dc_be_q    <= '0;
    end else if (grant_rd) begin
      dc_req_q   <= 1'b1;
      dc_we_q    <= 1'b0;
      dc_addr_q  <= port.mr_addr;
      dc_wdata_q <= 32'd0;
      dc_be_q    <= BE_ALL;
    end else if (grant_wr) begin
      dc_req_q   <= 1'b1;
      dc_we_q    <= 1'b1;
      dc_addr_q  <= port.mw_addr;
      dc_wdata_q <= port.mw_data;
      dc_be_q    <= port.mw_be;
    end else if (mr_done || mw_done) begin
      dc_req_q   <= 1'b0;
    end
  end

  // Read data is held until the next completed read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mr_rdata_q <= 32'd0;
    end else if (mr_done) begin
      mr_rdata_q <= port.dc_rdata;
    end
  end

  // A waiting read ages on each write grant; any read grant or an idle
  // cycle without a read request resets its age.
  assign starve_inc = grant_wr && port.mr_req;
  assign starve_clr = grant_rd || ((state_q == IDLE) && !port.mr_req);

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_i    (starve_inc),
    .clr_i    (starve_clr),
    .at_max_o (at_max),
    .cnt_o    (starve_cnt_o)
  );

  assign port.dc_req   = dc_req_q;
  assign port.dc_we    = dc_we_q;
  assign port.dc_addr  = dc_addr_q;
  assign port.dc_wdata = dc_wdata_q;
  assign port.dc_be    = dc_be_q;
  assign port.mr_done  = mr_done;
  assign port.mw_done  = mw_done;
  assign port.mr_rdata = mr_rdata_q;
  assign port.mr_stall = port.mr_req && !mr_done;
  assign port.mw_stall = port.mw_req && !mw_done;
  assign state_o       = state_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arb;
  import mem_pkg::*;

  localparam int SMAX = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arb_if bus ();
  state_t     dbg_state;
  logic [3:0] dbg_cnt;

  mem_port_arb #(
    .STARVE_MAX (SMAX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .port         (bus),
    .state_o      (dbg_state),
    .starve_cnt_o (dbg_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // One outstanding access record, the age of a waiting read (write grants
  // it has sat through), and the last read data delivered.
  bit          m_busy;
  bit          m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;
  int          m_starve;
  bit          last_mr_done, last_mw_done;
  logic [31:0] exp_q[$];     // read data expected in mr_rdata after a read ack
  logic        grant_log[$]; // 1 = write granted, 0 = read granted

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy   = 0;
    m_we     = 0;
    m_rdata  = 32'd0;
    m_starve = 0;
    exp_q.delete();
    last_mr_done = 0;
    last_mw_done = 0;
  endtask

  // Registered outputs, sampled 1 time unit after the rising edge.
  task automatic check_regs();
    logic [31:0] exp_state;
    exp_state = !m_busy ? 32'(IDLE) : (m_we ? 32'(WR) : 32'(RD));
    chk("dc_req", 32'(bus.dc_req), 32'(m_busy));
    chk("state", 32'(dbg_state), exp_state);
    chk("starve_cnt", 32'(dbg_cnt), 32'(m_starve));
    if (m_busy) begin
      chk("dc_we", 32'(bus.dc_we), 32'(m_we));
      chk("dc_addr", bus.dc_addr, m_addr);
      chk("dc_be", 32'(bus.dc_be), 32'(m_be));
      if (m_we) chk("dc_wdata", bus.dc_wdata, m_wdata);
    end
    if (exp_q.size() > 0) chk("mr_rdata_load", bus.mr_rdata, exp_q.pop_front());
    chk("mr_rdata_hold", bus.mr_rdata, m_rdata);
  endtask

  // One clock cycle with the inputs currently driven: check the
  // combinational outputs, advance the model by the arbitration rules,
  // then cross the edge and check the registered outputs.
  task automatic run_cycle();
    bit rd_done, wr_done, do_rd, do_wr;
    #1;
    rd_done = m_busy && !m_we && bus.dc_ack;
    wr_done = m_busy &&  m_we && bus.dc_ack;
    chk("mr_done", 32'(bus.mr_done), 32'(rd_done));
    chk("mw_done", 32'(bus.mw_done), 32'(wr_done));
    chk("mr_stall", 32'(bus.mr_stall), 32'(bus.mr_req && !rd_done));
    chk("mw_stall", 32'(bus.mw_stall), 32'(bus.mw_req && !wr_done));
    do_rd = 0;
    do_wr = 0;
    if (m_busy) begin
      if (bus.dc_ack) begin
        m_busy = 0;
        if (!m_we) begin
          m_rdata = bus.dc_rdata;
          exp_q.push_back(bus.dc_rdata);
        end
      end
    end else begin
      if (bus.mr_req && bus.mw_req) begin
        if (bus.mr_addr[31:2] == bus.mw_addr[31:2]) do_wr = 1;
        else if (m_starve == SMAX)                  do_rd = 1;
        else                                        do_wr = 1;
      end else if (bus.mr_req) begin
        do_rd = 1;
      end else if (bus.mw_req) begin
        do_wr = 1;
      end
      if (do_wr) begin
        m_busy = 1; m_we = 1; m_addr = bus.mw_addr; m_wdata = bus.mw_data; m_be = bus.mw_be;
        grant_log.push_back(1'b1);
        if (bus.mr_req) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
      end
      if (do_rd) begin
        m_busy = 1; m_we = 0; m_addr = bus.mr_addr; m_be = 4'hF;
        grant_log.push_back(1'b0);
        m_starve = 0;
      end
      if (!bus.mr_req) m_starve = 0;
    end
    last_mr_done = rd_done;
    last_mw_done = wr_done;
    @(posedge clk);
    #1;
    check_regs();
  endtask

  // ---------------- driver tasks ----------------
  // Requesters release their request once they see their done.
  task automatic step();
    run_cycle();
    if (last_mr_done) bus.mr_req = 1'b0;
    if (last_mw_done) bus.mw_req = 1'b0;
  endtask

  // Cache: wait lat busy cycles, then ack with read data d.
  task automatic ack_after(input int lat, input logic [31:0] d);
    repeat (lat) step();
    bus.dc_ack   = 1'b1;
    bus.dc_rdata = d;
    step();
    bus.dc_ack   = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    return 32'h100 + 32'($urandom_range(0, 3) << 2) + 32'($urandom_range(0, 3));
  endfunction

  logic [31:0] snap[$];
  int          done_cnt;
  bit          nxt_rd;

  // ---------------- stimulus ----------------
  initial begin
    rst_n        = 1'b0;
    bus.mr_req   = 1'b0; bus.mr_addr = 32'd0;
    bus.mw_req   = 1'b0; bus.mw_addr = 32'd0; bus.mw_data = 32'd0; bus.mw_be = 4'h0;
    bus.dc_ack   = 1'b0; bus.dc_rdata = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_regs();

    // Lone read, cache acks 2 cycles after dc_req.
    bus.mr_req = 1'b1; bus.mr_addr = 32'h100;
    step();
    chk("lone_dc_req", 32'(bus.dc_req), 32'd1);
    chk("lone_dc_be", 32'(bus.dc_be), 32'hF);
    ack_after(2, 32'hDEADBEEF);
    chk("lone_rdata", bus.mr_rdata, 32'hDEADBEEF);
    step();

    // Simultaneous requests to different words: write first, then read.
    grant_log.delete();
    bus.mr_req = 1'b1; bus.mr_addr = 32'h200;
    bus.mw_req = 1'b1; bus.mw_addr = 32'h300; bus.mw_data = 32'h12345678; bus.mw_be = 4'h3;
    step();
    chk("simul_we", 32'(bus.dc_we), 32'd1);
    chk("simul_be", 32'(bus.dc_be), 32'h3);
    chk("simul_cnt1", 32'(dbg_cnt), 32'd1);
    ack_after(0, 32'h0);
    step();
    chk("simul_rd_addr", bus.dc_addr, 32'h200);
    chk("simul_cnt0", 32'(dbg_cnt), 32'd0);
    ack_after(1, 32'hCAFEF00D);
    chk("simul_order_n", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      chk("simul_first_wr", 32'(grant_log[0]), 32'd1);
      chk("simul_then_rd", 32'(grant_log[1]), 32'd0);
    end
    step();

    // Starvation: three write grants, then the waiting read wins.
    grant_log.delete();
    snap.delete();
    bus.mr_req = 1'b1; bus.mr_addr = 32'h400;
    for (int i = 0; i < 4; i++) begin
      bus.mw_req = 1'b1; bus.mw_addr = 32'h1000 + 32'(16 * i);
      bus.mw_data = $urandom; bus.mw_be = 4'hF;
      step();
      snap.push_back(32'(dbg_cnt));
      ack_after(0, 32'h44440000 + 32'(i));
    end
    step();
    ack_after(0, 32'h0);
    chk("starve_cnt_after", 32'(dbg_cnt), 32'd0);
    chk("starve_grants_n", 32'(grant_log.size()), 32'd5);
    if (grant_log.size() == 5) begin
      chk("starve_g0", 32'(grant_log[0]), 32'd1);
      chk("starve_g1", 32'(grant_log[1]), 32'd1);
      chk("starve_g2", 32'(grant_log[2]), 32'd1);
      chk("starve_g3_rd", 32'(grant_log[3]), 32'd0);
    end
    chk("starve_snap0", snap[0], 32'd1);
    chk("starve_snap2", snap[2], 32'd3);
    chk("starve_snap3", snap[3], 32'd0);
    step();

    // Hazard: counter at max but same-word write still goes first.
    grant_log.delete();
    bus.mr_req = 1'b1; bus.mr_addr = 32'h503;
    for (int i = 0; i < 4; i++) begin
      bus.mw_req = 1'b1; bus.mw_addr = (i == 3) ? 32'h500 : 32'h700 + 32'(16 * i);
      bus.mw_data = $urandom; bus.mw_be = 4'h5;
      step();
      ack_after(1, 32'h0);
    end
    chk("hazard_cnt_sat", 32'(dbg_cnt), 32'd3);
    step();
    ack_after(0, 32'h5A5A5A5A);
    chk("hazard_grants_n", 32'(grant_log.size()), 32'd5);
    if (grant_log.size() == 5) begin
      chk("hazard_wr_first", 32'(grant_log[3]), 32'd1);
      chk("hazard_rd_last", 32'(grant_log[4]), 32'd0);
    end
    step();

    // Flush: read request drops mid-access; access still completes.
    bus.mr_req = 1'b1; bus.mr_addr = 32'h800;
    step();
    bus.mr_req = 1'b0;
    step();
    bus.dc_ack = 1'b1; bus.dc_rdata = 32'h0BADF00D;
    #1;
    chk("flush_done", 32'(bus.mr_done), 32'd1);
    step();
    bus.dc_ack = 1'b0;
    step();
    chk("flush_no_grant", 32'(bus.dc_req), 32'd0);
    step();

    // Reset in the middle of a write.
    bus.mw_req = 1'b1; bus.mw_addr = 32'h900; bus.mw_data = 32'h55AA55AA; bus.mw_be = 4'hF;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_dc_req", 32'(bus.dc_req), 32'd0);
    chk("rst_dc_we", 32'(bus.dc_we), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_rdata", bus.mr_rdata, 32'd0);
    bus.dc_ack = 1'b1;
    #1;
    chk("rst_ack_mw_done", 32'(bus.mw_done), 32'd0);
    chk("rst_ack_mr_done", 32'(bus.mr_done), 32'd0);
    bus.mw_req = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_regs();
    step();
    step();
    bus.dc_ack = 1'b0;

    // Zero-wait cache with alternating single requests.
    grant_log.delete();
    bus.dc_ack = 1'b1;
    done_cnt = 0;
    nxt_rd = 1;
    for (int i = 0; i < 8; i++) begin
      if (!bus.mr_req && !bus.mw_req) begin
        if (nxt_rd) begin
          bus.mr_req = 1'b1; bus.mr_addr = 32'hA00 + 32'(4 * i);
        end else begin
          bus.mw_req = 1'b1; bus.mw_addr = 32'hB00 + 32'(4 * i);
          bus.mw_data = $urandom; bus.mw_be = 4'h9;
        end
        nxt_rd = !nxt_rd;
      end
      bus.dc_rdata = $urandom;
      step();
      if (last_mr_done || last_mw_done) done_cnt++;
    end
    bus.dc_ack = 1'b0;
    chk("zw_done_cnt", 32'(done_cnt), 32'd4);
    step();

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      if (!bus.mr_req && $urandom_range(0, 2) == 0) begin
        bus.mr_req = 1'b1; bus.mr_addr = pick_addr();
      end else if (bus.mr_req && $urandom_range(0, 40) == 0) begin
        bus.mr_req = 1'b0;
      end
      if (!bus.mw_req && $urandom_range(0, 2) == 0) begin
        bus.mw_req  = 1'b1; bus.mw_addr = pick_addr();
        bus.mw_data = $urandom; bus.mw_be = 4'($urandom_range(1, 15));
      end
      bus.dc_ack   = ($urandom_range(0, 2) == 0);
      bus.dc_rdata = $urandom;
      step();
    end
    bus.mr_req = 1'b0; bus.mw_req = 1'b0;
    bus.dc_ack = 1'b1;
    repeat (3) step();
    bus.dc_ack = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
